// File: rtl/uart_rx_ctrl.sv
// Autobaud and receive-sequencing controller: measures the start bit of a 0x55
// sync character, programs/enables uart_rx and buffers bytes in a 4-deep FIFO.
module uart_rx_ctrl #(
  parameter int unsigned DEFAULT_CLKS = 521,
  parameter int unsigned MIN_CLKS     = 16,
  parameter int unsigned MAX_CLKS     = 8192,
  parameter int unsigned IDLE_CLKS    = 16
) (
  input  logic        rx_clk,
  input  logic        rst,
  input  logic        rx_in,
  input  logic        start,
  output logic [15:0] cfg_clks_per_bit,
  output logic        rx_en,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        locked,
  output logic        err_timeout,
  output logic        overflow
);

  localparam logic [15:0] DEF_C  = 16'(DEFAULT_CLKS);
  localparam logic [15:0] MIN_C  = 16'(MIN_CLKS);
  localparam logic [15:0] MAX_C  = 16'(MAX_CLKS);
  localparam logic [15:0] IDLE_C = 16'(IDLE_CLKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_FALL,
    S_MEASURE,
    S_SKIP,
    S_LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] per_q, per_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] cfg_q, cfg_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];

  logic line, fall, push, pop, full, wr_en;

  always_comb begin
    sync1_d  = rx_in;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    line     = sync2_q;
    fall     = prev_q & ~sync2_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    bit_d    = bit_q;
    cfg_d    = cfg_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    case (state_q)
      S_WAIT_IDLE: begin
        if (!line) begin
          cnt_d = 16'd0;
        end else if (cnt_q + 16'd1 >= IDLE_C) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT_FALL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_FALL: begin
        if (fall) begin
          cnt_d   = 16'd1;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        // The synced line is the only reference, so cnt equals the raw low width.
        if (line) begin
          if (cnt_q < MIN_C) begin
            state_d = S_WAIT_FALL;
          end else begin
            cfg_d   = cnt_q;
            per_d   = 16'd1;
            bit_d   = 4'd0;
            state_d = S_SKIP;
          end
        end else if (cnt_q + 16'd1 >= MAX_C) begin
          cnt_d   = MAX_C;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SKIP: begin
        // Nine whole bit periods: per counts 1..cfg, bit counts 0..8.
        if (per_q == cfg_q) begin
          per_d = 16'd1;
          if (bit_q == 4'd8) begin
            state_d = S_LOCKED;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          per_d = per_q + 16'd1;
        end
      end
      default: ;
    endcase

    push  = (state_q == S_LOCKED) & rx_done;
    pop   = (count_q != 3'd0) & out_ready;
    full  = (count_q == 3'd4);
    wr_en = push & (~full | pop);

    if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
    if (wr_en) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    count_d = count_q + {2'b00, wr_en} - {2'b00, pop};

    // A start always wins: restart sequencing, flush FIFO, clear sticky flags.
    if (start) begin
      state_d  = S_WAIT_IDLE;
      cnt_d    = 16'd0;
      err_d    = 1'b0;
      ovf_d    = 1'b0;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      count_d  = 3'd0;
    end
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      cnt_q    <= 16'd0;
      per_q    <= 16'd0;
      bit_q    <= 4'd0;
      cfg_q    <= DEF_C;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      bit_q    <= bit_d;
      cfg_q    <= cfg_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge rx_clk) begin
    mem_q <= mem_d;
  end

  assign cfg_clks_per_bit = cfg_q;
  assign rx_en            = (state_q == S_LOCKED);
  assign locked           = (state_q == S_LOCKED);
  assign err_timeout      = err_q;
  assign overflow         = ovf_q;
  assign out_valid        = (count_q != 3'd0);
  assign out_data         = out_valid ? mem_q[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: autobaud lock timing, glitch, timeout, reset,
// restart, and a scoreboard that checks FIFO bytes whenever the DUT hands one over.
module tb_uart_rx_ctrl;

  logic        rx_clk = 1'b0;
  logic        rst, rx_in, start, rx_done, out_ready;
  logic [7:0]  rx_data;
  logic [15:0] cfg_clks_per_bit;
  logic        rx_en, out_valid, locked, err_timeout, overflow;
  logic [7:0]  out_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  uart_rx_ctrl dut (
    .rx_clk           (rx_clk),
    .rst              (rst),
    .rx_in            (rx_in),
    .start            (start),
    .cfg_clks_per_bit (cfg_clks_per_bit),
    .rx_en            (rx_en),
    .rx_done          (rx_done),
    .rx_data          (rx_data),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .locked           (locked),
    .err_timeout      (err_timeout),
    .overflow         (overflow)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted handoff pops the next expected byte.
  always @(negedge rx_clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no byte", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_data", {24'd0, out_data}, {24'd0, mon_exp});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
  endtask

  // Sends 0x55 at cpb clocks/bit and checks the exact lock cycle: 2 sync
  // cycles + 9*cpb SKIP cycles + 1 registered transition after the raw rise.
  task automatic send_55(input int cpb);
    logic [7:0] sb;
    sb = 8'h55;
    rx_in = 1'b0;
    cyc(cpb);
    for (int b = 0; b < 9; b++) begin
      rx_in = (b == 8) ? 1'b1 : sb[b];
      cyc(cpb);
    end
    repeat (2) @(posedge rx_clk);
    @(negedge rx_clk);
    check("locked_early", {31'd0, locked}, 32'd0);
    @(posedge rx_clk);
    @(negedge rx_clk);
    check("locked_rise", {31'd0, locked}, 32'd1);
    check("rx_en_rise", {31'd0, rx_en}, 32'd1);
    check("cfg_measured", {16'd0, cfg_clks_per_bit}, cpb);
    check("no_timeout", {31'd0, err_timeout}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_in = 1'b1; start = 1'b0; rx_done = 1'b0;
    out_ready = 1'b0; rx_data = 8'h00;
    cyc(3);
    check("rst_cfg", {16'd0, cfg_clks_per_bit}, 32'd521);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    cyc(3);

    // Glitch rejection then lock at 100.
    pulse_start();
    cyc(20);
    rx_in = 1'b0; cyc(5);
    rx_in = 1'b1; cyc(20);
    send_55(100);

    // Asynchronous reset mid-MEASURE.
    pulse_start();
    cyc(20);
    rx_in = 1'b0;
    cyc(40);
    #2 rst = 1'b1;
    #1;
    check("amid_cfg", {16'd0, cfg_clks_per_bit}, 32'd521);
    check("amid_locked", {31'd0, locked}, 32'd0);
    check("amid_rx_en", {31'd0, rx_en}, 32'd0);
    check("amid_err", {31'd0, err_timeout}, 32'd0);
    check("amid_ovf", {31'd0, overflow}, 32'd0);
    cyc(2);
    rst = 1'b0; rx_in = 1'b1;
    cyc(5);

    // Nominal lock at 521.
    pulse_start();
    cyc(20);
    send_55(521);

    // FIFO: fill, push+pop while full, overflow, drain.
    cyc(2);
    check("fifo_empty0", {31'd0, out_valid}, 32'd0);
    push(8'h11); exp_q.push_back(8'h11);
    @(negedge rx_clk);
    check("done_to_valid", {31'd0, out_valid}, 32'd1);
    cyc(1);
    push(8'h22); exp_q.push_back(8'h22);
    push(8'h33); exp_q.push_back(8'h33);
    push(8'h44); exp_q.push_back(8'h44);
    check("full_head", {24'd0, out_data}, 32'h11);
    out_ready = 1'b1;
    push(8'h55); exp_q.push_back(8'h55);
    out_ready = 1'b0;
    check("pushpop_no_ovf", {31'd0, overflow}, 32'd0);
    push(8'h66);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    cyc(3);
    check("head_stable", {24'd0, out_data}, 32'h22);
    out_ready = 1'b1;
    cyc(4);
    @(negedge rx_clk);
    check("drained", {31'd0, out_valid}, 32'd0);
    cyc(1);
    out_ready = 1'b0;

    // Restart with two bytes queued, then relock at 260.
    push(8'h77);
    push(8'h88);
    check("queued_valid", {31'd0, out_valid}, 32'd1);
    check("queued_head", {24'd0, out_data}, 32'h77);
    pulse_start();
    @(negedge rx_clk);
    check("rs_locked", {31'd0, locked}, 32'd0);
    check("rs_rx_en", {31'd0, rx_en}, 32'd0);
    check("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check("rs_ovf", {31'd0, overflow}, 32'd0);
    check("rs_cfg_hold", {16'd0, cfg_clks_per_bit}, 32'd521);
    cyc(20);
    send_55(260);

    // Timeout: line held low 9000 cycles.
    pulse_start();
    cyc(20);
    rx_in = 1'b0;
    repeat (8193) @(posedge rx_clk);
    @(negedge rx_clk);
    check("timeout_early", {31'd0, err_timeout}, 32'd0);
    @(posedge rx_clk);
    @(negedge rx_clk);
    check("timeout_set", {31'd0, err_timeout}, 32'd1);
    check("timeout_locked", {31'd0, locked}, 32'd0);
    check("timeout_cfg", {16'd0, cfg_clks_per_bit}, 32'd260);
    cyc(805);
    rx_in = 1'b1;
    cyc(20);
    check("timeout_sticky", {31'd0, err_timeout}, 32'd1);
    check("timeout_cfg_hold", {16'd0, cfg_clks_per_bit}, 32'd260);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
